i2c_cond_generator: RTL
=======================

# i2c_cond_generator

Master-side I2C bus-condition generator: drives START, repeated START and STOP conditions onto open-drain SCL/SDA with programmable setup, hold, low and bus-free times counted in `clk` cycles. It is the transmit-side counterpart of `stop_detector` and sits between the byte-level master controller and the pad open-drain drivers. Lines are driven as release (1) or pull-low (0) levels; pads implement the open-drain behaviour.

## Interface
- `T_SU`, default 5: setup time in clk cycles, SCL high before SDA edge.
- `T_HD`, default 4: START hold time, SDA low with SCL high.
- `T_LOW`, default 5: SCL low time before a STOP or repeated START.
- `T_BUF`, default 6: bus-free time after STOP.
- `CNT_W`, default 16: phase counter width; all `T_*` < 2^CNT_W.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: block enable; sampled only at command accept.
- `cmd_valid` input 1: command request.
- `cmd` input 2: 01 START, 10 STOP, 11 RSTART, 00 reserved.
- `scl_in` input 1: sampled SCL pad level.
- `ready` output 1: able to accept a command.
- `done` output 1: one-cycle pulse when a condition completes.
- `err` output 1: one-cycle pulse on a rejected command.
- `held` output 1: bus owned (after START/RSTART, until STOP completes).
- `scl_out` output 1: SCL drive, 1 = release, 0 = pull low.
- `sda_out` output 1: SDA drive, 1 = release, 0 = pull low.

## Operation
- States: IDLE, R_LOW, S_SU, S_HD, P_LOW, P_SU, P_BUF. Every output is registered.
- Reset values: `scl_out`=1, `sda_out`=1, `ready`=1, `done`=0, `err`=0, `held`=0, state IDLE.
- `ready`=1 only in IDLE. A command is accepted on the edge where `cmd_valid`&&`ready`&&`enable`. When `enable`=0, `cmd_valid` is ignored with no `err`.
- Legality:
  - START is legal only with `held`=0.
  - STOP and RSTART are legal only with `held`=1.
  - Cmd 00 or an illegal cmd pulses `err` on the next cycle. The state stays IDLE and the lines do not change.
- Phase levels and lengths (`scl`/`sda`, cycles):
  - R_LOW: 0/1 for T_LOW
  - S_SU: 1/1 for T_SU
  - S_HD: 1/0 for T_HD
  - P_LOW: 0/0 for T_LOW
  - P_SU: 1/0 for T_SU
  - P_BUF: 1/1 for T_BUF
- Sequences:
  - START: S_SU → S_HD → IDLE.
  - RSTART: R_LOW → S_SU → S_HD → IDLE.
  - STOP: P_LOW → P_SU → P_BUF → IDLE.
- Final levels on return to IDLE:
  - After START or RSTART: `scl_out`=0, `sda_out`=0, `held`=1.
  - After STOP: both released, `held`=0.
- The counter loads `T_x`-1 on phase entry and advances at 0. A parameter value of 0 behaves as 1.
- Async reset mid-sequence returns to IDLE immediately. Both lines are released and `held` clears. No `done` is generated.

## Timing
- Accept at edge 0 → first phase levels visible from cycle 1.
- `done` and `ready` are high together in the cycle after the last phase cycle:
  - START: cycle 1+T_SU+T_HD.
  - RSTART: cycle 1+T_LOW+T_SU+T_HD.
  - STOP: cycle 1+T_LOW+T_SU+T_BUF.
- Back-to-back: a command presented while `done`=1 is accepted on that edge, giving zero idle cycles between conditions.
- SDA never changes in the same cycle as SCL rises. SDA changes while SCL is high occur only at the S_SU→S_HD boundary (START) and the P_SU→P_BUF boundary (STOP).

## Configuration
- `I2C_CLOCK_STRETCH_EN`:
  - Defined: in any phase with `scl_out`=1, the phase counter holds while `scl_in`=0. Every phase latency extends by the number of stretched cycles.
  - Undefined: `scl_in` is ignored and latencies are exactly as listed under Timing.

## Test plan
- Reset, then START with defaults. Required response:
  - `sda_out` falls at cycle 6; `scl_out` falls and `done`=1 at cycle 10; `held`=1.
  - A `stop_detector` monitor stays low.
- After START, STOP with defaults:
  - SCL/SDA 0/0 for cycles 1–5, 1/0 for 6–10, 1/1 for 11–16.
  - `done`=1 at cycle 17; `held`=0; `stop_detector.stop` fires once.
- After START, RSTART:
  - Levels 0/1 for 5 cycles, 1/1 for 5, 1/0 for 4.
  - `done`=1 at cycle 15; `held` stays 1.
- Illegal commands:
  - STOP with `held`=0 → `err` pulse, lines unchanged.
  - START with `held`=1 → `err` pulse.
  - cmd 00 → `err` pulse.
  - `enable`=0 with `cmd_valid`=1 → no accept and no `err`.
- Assert `rst_n` low during the P_SU phase of a STOP → both lines 1 and `held`=0 asynchronously, no `done`. After release, START works.
- With `I2C_CLOCK_STRETCH_EN` defined, a START with `scl_in` held low for 3 cycles during S_SU → `done` at cycle 13.

Source files
------------

// File: rtl/i2c_cond_generator.sv
// i2c_cond_generator
// Master-side I2C bus-condition generator. Produces START, repeated START
// and STOP conditions on open-drain SCL/SDA drive levels (1 = release,
// 0 = pull low). Setup, hold, low and bus-free times are counted in clk
// cycles.
//
// Optional feature macro: I2C_CLOCK_STRETCH_EN
//   When defined, the phase counter holds in any phase that releases SCL
//   while the sampled SCL pad level is still low. This lets a slave stretch
//   the clock.
//   When undefined, scl_in is ignored.
module i2c_cond_generator #(
    parameter int unsigned T_SU  = 5,
    parameter int unsigned T_HD  = 4,
    parameter int unsigned T_LOW = 5,
    parameter int unsigned T_BUF = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic       scl_in,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic       held,
    output logic       scl_out,
    output logic       sda_out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_R_LOW = 3'd1,
        ST_S_SU  = 3'd2,
        ST_S_HD  = 3'd3,
        ST_P_LOW = 3'd4,
        ST_P_SU  = 3'd5,
        ST_P_BUF = 3'd6
    } state_t;

    localparam logic [1:0] CMD_START  = 2'b01;
    localparam logic [1:0] CMD_STOP   = 2'b10;
    localparam logic [1:0] CMD_RSTART = 2'b11;

    // Counter reload values: a phase of T cycles loads T-1 and advances at
    // zero. A parameter of 0 is treated as a one-cycle phase.
    localparam logic [CNT_W-1:0] LD_SU  = (T_SU  == 0) ? '0 : CNT_W'(T_SU  - 1);
    localparam logic [CNT_W-1:0] LD_HD  = (T_HD  == 0) ? '0 : CNT_W'(T_HD  - 1);
    localparam logic [CNT_W-1:0] LD_LOW = (T_LOW == 0) ? '0 : CNT_W'(T_LOW - 1);
    localparam logic [CNT_W-1:0] LD_BUF = (T_BUF == 0) ? '0 : CNT_W'(T_BUF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              scl_q,   scl_d;
    logic              sda_q,   sda_d;
    logic              held_q,  held_d;
    logic              ready_q, ready_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;

    logic              hold_s;
    logic              phase_end_s;

`ifdef I2C_CLOCK_STRETCH_EN
    // A released SCL that still reads low means a slave is stretching.
    assign hold_s = scl_q & ~scl_in & (state_q != ST_IDLE);
`else
    logic unused_scl_in_s;
    assign unused_scl_in_s = scl_in;
    assign hold_s          = 1'b0;
`endif

    // The last cycle of a phase is the one where the counter sits at zero
    // and is not being held by clock stretching.
    assign phase_end_s = ~hold_s & (cnt_q == '0);

    // Next-state, counter and output-level computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scl_d   = scl_q;
        sda_d   = sda_q;
        held_d  = held_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // Generic phase countdown; transitions below override the reload.
        if (state_q != ST_IDLE && !hold_s && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q && enable) begin
                    case (cmd)
                        CMD_START: begin
                            if (!held_q) begin
                                state_d = ST_S_SU;
                                cnt_d   = LD_SU;
                                scl_d   = 1'b1;
                                sda_d   = 1'b1;
                            end else begin
                                err_d   = 1'b1;
                            end
                        end
                        CMD_STOP: begin
                            if (held_q) begin
                                state_d = ST_P_LOW;
                                cnt_d   = LD_LOW;
                                scl_d   = 1'b0;
                                sda_d   = 1'b0;
                            end else begin
                                err_d   = 1'b1;
                            end
                        end
                        CMD_RSTART: begin
                            if (held_q) begin
                                state_d = ST_R_LOW;
                                cnt_d   = LD_LOW;
                                scl_d   = 1'b0;
                                sda_d   = 1'b1;
                            end else begin
                                err_d   = 1'b1;
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_R_LOW: begin
                // SDA was released while SCL is low; now raise SCL.
                if (phase_end_s) begin
                    state_d = ST_S_SU;
                    cnt_d   = LD_SU;
                    scl_d   = 1'b1;
                    sda_d   = 1'b1;
                end else begin
                    state_d = ST_R_LOW;
                end
            end
            ST_S_SU: begin
                // SDA falls with SCL high: the START edge.
                if (phase_end_s) begin
                    state_d = ST_S_HD;
                    cnt_d   = LD_HD;
                    scl_d   = 1'b1;
                    sda_d   = 1'b0;
                end else begin
                    state_d = ST_S_SU;
                end
            end
            ST_S_HD: begin
                // Pull SCL low to hand the bus to the byte engine.
                if (phase_end_s) begin
                    state_d = ST_IDLE;
                    scl_d   = 1'b0;
                    sda_d   = 1'b0;
                    held_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_S_HD;
                end
            end
            ST_P_LOW: begin
                // Raise SCL while keeping SDA low.
                if (phase_end_s) begin
                    state_d = ST_P_SU;
                    cnt_d   = LD_SU;
                    scl_d   = 1'b1;
                    sda_d   = 1'b0;
                end else begin
                    state_d = ST_P_LOW;
                end
            end
            ST_P_SU: begin
                // SDA rises with SCL high: the STOP edge.
                if (phase_end_s) begin
                    state_d = ST_P_BUF;
                    cnt_d   = LD_BUF;
                    scl_d   = 1'b1;
                    sda_d   = 1'b1;
                end else begin
                    state_d = ST_P_SU;
                end
            end
            ST_P_BUF: begin
                // Bus-free time elapsed; bus is released.
                if (phase_end_s) begin
                    state_d = ST_IDLE;
                    scl_d   = 1'b1;
                    sda_d   = 1'b1;
                    held_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_P_BUF;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                scl_d   = 1'b1;
                sda_d   = 1'b1;
                held_d  = 1'b0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State, counter and registered outputs; reset releases both lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            held_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            held_q  <= held_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign err     = err_q;
    assign held    = held_q;
    assign scl_out = scl_q;
    assign sda_out = sda_q;

endmodule
